// File: rtl/gp0_pkg.sv
// Shared types and command decode for the GP0 command sequencer.
// Read alongside gp0_cmd_sequencer.sv (optional feature macro: GP0_POLYLINE_CAP_EN).
package gp0_pkg;

    typedef enum logic [3:0] {
        CLS_MISC,
        CLS_FILL,
        CLS_POLY,
        CLS_LINE,
        CLS_RECT,
        CLS_COPY,
        CLS_TOVRAM,
        CLS_FROMVRAM,
        CLS_ENV
    } cmd_class_e;

    typedef enum logic [1:0] {
        ST_CMD,
        ST_PARAM,
        ST_POLY,
        ST_DATA
    } seq_state_e;

    localparam logic [31:0] TERM_MASK  = 32'hF000_F000;
    localparam logic [31:0] TERM_VALUE = 32'h5000_5000;

    typedef struct packed {
        logic [31:0] word;
        logic        sop;
        logic        eop;
        logic        is_data;
        logic [7:0]  cmd;
    } out_entry_t;

    function automatic cmd_class_e cmd_class(input logic [7:0] cmd);
        cmd_class_e cls;
        case (cmd[7:5])
            3'd0:    cls = (cmd == 8'h02) ? CLS_FILL : CLS_MISC;
            3'd1:    cls = CLS_POLY;
            3'd2:    cls = CLS_LINE;
            3'd3:    cls = CLS_RECT;
            3'd4:    cls = CLS_COPY;
            3'd5:    cls = CLS_TOVRAM;
            3'd6:    cls = CLS_FROMVRAM;
            default: cls = CLS_ENV;
        endcase
        return cls;
    endfunction

    // Fixed packet length including the command word; for polylines this is the
    // minimum before the terminator search starts, for VRAM writes the header only.
    function automatic logic [4:0] cmd_word_count(input logic [7:0] cmd);
        logic [4:0] nv;
        logic [4:0] cnt;
        nv  = cmd[3] ? 5'd4 : 5'd3;
        cnt = 5'd1;
        case (cmd_class(cmd))
            CLS_FILL:     cnt = 5'd3;
            CLS_POLY:     cnt = 5'd1 + (cmd[2] ? (nv << 1) : nv) + (cmd[4] ? (nv - 5'd1) : 5'd0);
            CLS_LINE:     cnt = cmd[4] ? 5'd4 : 5'd3;
            CLS_RECT:     cnt = 5'd2 + {4'd0, cmd[2]} + ((cmd[4:3] == 2'b00) ? 5'd1 : 5'd0);
            CLS_COPY:     cnt = 5'd4;
            CLS_TOVRAM:   cnt = 5'd3;
            CLS_FROMVRAM: cnt = 5'd3;
            default:      cnt = 5'd1;
        endcase
        return cnt;
    endfunction

endpackage

// File: rtl/gp0_out_skid.sv
// Two-entry output buffer carrying a tagged word towards the primitive setup stage.
// Head is always slot0 so the outputs hold steady while downstream stalls.
module gp0_out_skid
    import gp0_pkg::*;
(
    input  logic       clk,
    input  logic       nRst,
    input  logic       in_valid,
    input  out_entry_t in_entry,
    output logic       out_valid,
    output out_entry_t out_entry,
    input  logic       out_ready,
    output logic [1:0] count
);

    out_entry_t slot0;
    out_entry_t slot1;
    logic [1:0] cnt;
    logic       pop;

    assign out_valid = (cnt != 2'd0);
    assign out_entry = slot0;
    assign count     = cnt;
    assign pop       = out_valid && out_ready;

    always_ff @(posedge clk or negedge nRst) begin
        if (!nRst) begin
            slot0 <= '0;
            slot1 <= '0;
            cnt   <= 2'd0;
        end else begin
            case ({in_valid, pop})
                2'b10: begin
                    if (cnt == 2'd0) slot0 <= in_entry;
                    else             slot1 <= in_entry;
                    cnt <= cnt + 2'd1;
                end
                2'b01: begin
                    slot0 <= slot1;
                    cnt   <= cnt - 2'd1;
                end
                2'b11: begin
                    if (cnt == 2'd1) begin
                        slot0 <= in_entry;
                    end else begin
                        slot0 <= slot1;
                        slot1 <= in_entry;
                    end
                end
                default: ;
            endcase
        end
    end

    // The upstream pop rule must never let a word arrive into a full buffer.
    assert property (@(posedge clk) disable iff (!nRst) !(in_valid && !pop && cnt == 2'd2));

endmodule

// File: rtl/gp0_cmd_sequencer.sv
// GP0 FIFO consumer: tags words as command/parameter/pixel data and frames packets.
// Optional macro GP0_POLYLINE_CAP_EN forces a polyline closed at its 256th vertex.
module gp0_cmd_sequencer #(
    parameter int BUF_DEPTH = 2
) (
    input  logic        clk,
    input  logic        nRst,
    input  logic [31:0] i_fifo_data,
    input  logic        i_fifo_empty,
    output logic        o_fifo_rd,
    output logic [31:0] o_word,
    output logic        o_valid,
    input  logic        i_ready,
    output logic        o_sop,
    output logic        o_eop,
    output logic        o_is_data,
    output logic [7:0]  o_cmd,
    output logic        o_busy
);
    import gp0_pkg::*;

    seq_state_e  state;
    logic [18:0] remaining;
    logic [7:0]  cur_cmd;
    logic        pend;

    logic [1:0]  buf_cnt;
    logic        head_valid;
    out_entry_t  head;
    out_entry_t  in_entry;
    logic        consume;
    logic [2:0]  occ_next;

    logic [4:0]  new_total;
    logic        rem_last;
    logic        to_data;
    logic        to_poly;
    logic        term_hit;
    logic        poly_end;

    logic [9:0]  w_m1;
    logic [8:0]  h_m1;
    logic [19:0] w_px;
    logic [19:0] h_px;
    logic [19:0] px_prod;
    logic [19:0] px_plus;
    logic [18:0] data_words;

`ifdef GP0_POLYLINE_CAP_EN
    logic [8:0]  vtx_cnt;
    logic        vtx_phase;
    logic        vtx_step;
    logic        cap_hit;
`endif

    assign consume  = head_valid && i_ready;
    assign occ_next = {1'b0, buf_cnt} + {2'b0, pend} - {2'b0, consume};
    assign o_fifo_rd = nRst && !i_fifo_empty && (occ_next < 3'(BUF_DEPTH));

    // Pixel count from the size word: 0 wraps to the maximum extent in each axis.
    always_comb begin
        w_m1       = i_fifo_data[9:0] - 10'd1;
        h_m1       = i_fifo_data[24:16] - 9'd1;
        w_px       = {10'd0, w_m1} + 20'd1;
        h_px       = {11'd0, h_m1} + 20'd1;
        px_prod    = w_px * h_px;
        px_plus    = px_prod + 20'd1;
        data_words = px_plus[19:1];
    end

    always_comb begin
        new_total = cmd_word_count(i_fifo_data[31:24]);
        rem_last  = (remaining == 19'd1);
        to_data   = (cmd_class(cur_cmd) == CLS_TOVRAM);
        to_poly   = (cmd_class(cur_cmd) == CLS_LINE) && cur_cmd[3];
        term_hit  = ((i_fifo_data & TERM_MASK) == TERM_VALUE);
`ifdef GP0_POLYLINE_CAP_EN
        vtx_step  = !cur_cmd[4] || vtx_phase;
        cap_hit   = !term_hit && vtx_step && (vtx_cnt == 9'd255);
        poly_end  = term_hit || cap_hit;
`else
        poly_end  = term_hit;
`endif
    end

    always_comb begin
        in_entry.word    = i_fifo_data;
        in_entry.sop     = (state == ST_CMD);
        in_entry.is_data = (state == ST_DATA);
        in_entry.cmd     = (state == ST_CMD) ? i_fifo_data[31:24] : cur_cmd;
        in_entry.eop     = 1'b0;
        case (state)
            ST_CMD:   in_entry.eop = (new_total == 5'd1);
            ST_PARAM: in_entry.eop = rem_last && !to_data && !to_poly;
            ST_POLY:  in_entry.eop = poly_end;
            ST_DATA:  in_entry.eop = rem_last;
            default:  in_entry.eop = 1'b0;
        endcase
    end

    // Classifier advances only on cycles where a popped word is arriving.
    always_ff @(posedge clk or negedge nRst) begin
        if (!nRst) begin
            state     <= ST_CMD;
            remaining <= 19'd0;
            cur_cmd   <= 8'h00;
            pend      <= 1'b0;
`ifdef GP0_POLYLINE_CAP_EN
            vtx_cnt   <= 9'd0;
            vtx_phase <= 1'b0;
`endif
        end else begin
            pend <= o_fifo_rd;
            if (pend) begin
                case (state)
                    ST_CMD: begin
                        cur_cmd <= i_fifo_data[31:24];
                        if (new_total != 5'd1) begin
                            remaining <= {14'd0, new_total - 5'd1};
                            state     <= ST_PARAM;
                        end
                    end
                    ST_PARAM: begin
                        remaining <= remaining - 19'd1;
                        if (rem_last) begin
                            if (to_data) begin
                                remaining <= data_words;
                                state     <= ST_DATA;
                            end else if (to_poly) begin
                                state <= ST_POLY;
`ifdef GP0_POLYLINE_CAP_EN
                                vtx_cnt   <= 9'd2;
                                vtx_phase <= 1'b0;
`endif
                            end else begin
                                state <= ST_CMD;
                            end
                        end
                    end
                    ST_POLY: begin
                        if (poly_end) begin
                            state <= ST_CMD;
                        end
`ifdef GP0_POLYLINE_CAP_EN
                        else begin
                            if (vtx_step) vtx_cnt <= vtx_cnt + 9'd1;
                            vtx_phase <= cur_cmd[4] ? !vtx_phase : 1'b0;
                        end
`endif
                    end
                    ST_DATA: begin
                        remaining <= remaining - 19'd1;
                        if (rem_last) state <= ST_CMD;
                    end
                    default: state <= ST_CMD;
                endcase
            end
        end
    end

    gp0_out_skid u_skid (
        .clk       (clk),
        .nRst      (nRst),
        .in_valid  (pend),
        .in_entry  (in_entry),
        .out_valid (head_valid),
        .out_entry (head),
        .out_ready (i_ready),
        .count     (buf_cnt)
    );

    assign o_valid   = head_valid;
    assign o_word    = head.word;
    assign o_sop     = head.sop;
    assign o_eop     = head.eop;
    assign o_is_data = head.is_data;
    assign o_cmd     = head.cmd;
    assign o_busy    = (state != ST_CMD) || head_valid || pend;

endmodule

// File: tb/tb_gp0_cmd_sequencer.sv
// Self-checking bench for gp0_cmd_sequencer: vector tables feed a FIFO model and a
// scoreboard of expected tagged words; hand-written sequences cover reset and stalls.
module tb_gp0_cmd_sequencer;

    typedef struct {
        logic [31:0] word;
        logic        sop;
        logic        eop;
        logic        is_data;
        logic [7:0]  cmd;
    } vec_t;

    logic        clk = 1'b0;
    logic        nRst = 1'b0;
    logic [31:0] i_fifo_data = 32'd0;
    logic        i_fifo_empty = 1'b1;
    logic        i_ready = 1'b1;
    logic        o_fifo_rd;
    logic [31:0] o_word;
    logic        o_valid;
    logic        o_sop;
    logic        o_eop;
    logic        o_is_data;
    logic [7:0]  o_cmd;
    logic        o_busy;

    int          checks = 0;
    int          failures = 0;
    int          cyc = 0;
    int          occ = 0;
    int          pend_m = 0;
    logic        stalled = 1'b0;
    vec_t        stall_v;
    logic [31:0] fifo_q[$];
    vec_t        exp_q[$];
    vec_t        tbl[$];
    int          xfer_cyc[$];
    bit          ready_pat [4] = '{1'b1, 1'b0, 1'b0, 1'b1};

    gp0_cmd_sequencer #(.BUF_DEPTH(2)) dut (
        .clk          (clk),
        .nRst         (nRst),
        .i_fifo_data  (i_fifo_data),
        .i_fifo_empty (i_fifo_empty),
        .o_fifo_rd    (o_fifo_rd),
        .o_word       (o_word),
        .o_valid      (o_valid),
        .i_ready      (i_ready),
        .o_sop        (o_sop),
        .o_eop        (o_eop),
        .o_is_data    (o_is_data),
        .o_cmd        (o_cmd),
        .o_busy       (o_busy)
    );

    always #5 clk = ~clk;

    // FIFO with a registered read port: data appears the cycle after the pop strobe.
    always @(posedge clk) begin
        cyc <= cyc + 1;
        if (nRst && o_fifo_rd) begin
            if (fifo_q.size() > 0) i_fifo_data <= fifo_q.pop_front();
            else                   i_fifo_data <= 32'hDEAD_BEEF;
        end
        i_fifo_empty <= (fifo_q.size() == 0);
    end

    initial begin
        #400000;
        $display("[TB] FAIL watchdog elapsed cycles=%0d required=finish", cyc);
        $fatal(1, "[TB] watchdog");
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("[TB] FAIL %s actual=%h required=%h", name, act, req);
        end
    endtask

    // Monitor step taken at the falling edge, away from the DUT's active edge.
    task automatic checkOutput();
        int   c;
        vec_t e;
        if (!nRst) begin
            occ     = 0;
            pend_m  = 0;
            stalled = 1'b0;
        end else begin
            c = (o_valid && i_ready) ? 1 : 0;
            chk("valid_latency", {31'd0, o_valid}, {31'd0, occ != 0});
            if (o_fifo_rd) begin
                checks++;
                if (occ + pend_m - c >= 2) begin
                    failures++;
                    $display("[TB] FAIL pop_rule occupancy=%0d required<2", occ + pend_m - c);
                end
            end
            if (stalled) begin
                checks++;
                if (!o_valid || o_word !== stall_v.word || o_sop !== stall_v.sop ||
                    o_eop !== stall_v.eop || o_is_data !== stall_v.is_data || o_cmd !== stall_v.cmd) begin
                    failures++;
                    $display("[TB] FAIL stall_hold word=%h valid=%b required word=%h valid=1",
                             o_word, o_valid, stall_v.word);
                end
            end
            stalled         = o_valid && !i_ready;
            stall_v.word    = o_word;
            stall_v.sop     = o_sop;
            stall_v.eop     = o_eop;
            stall_v.is_data = o_is_data;
            stall_v.cmd     = o_cmd;
            if (c == 1) begin
                checks++;
                if (exp_q.size() == 0) begin
                    failures++;
                    $display("[TB] FAIL unexpected_word word=%h required=none", o_word);
                end else begin
                    e = exp_q.pop_front();
                    if (o_word !== e.word || o_sop !== e.sop || o_eop !== e.eop ||
                        o_is_data !== e.is_data || o_cmd !== e.cmd) begin
                        failures++;
                        $display("[TB] FAIL xfer word=%h sop=%b eop=%b data=%b cmd=%h required word=%h sop=%b eop=%b data=%b cmd=%h",
                                 o_word, o_sop, o_eop, o_is_data, o_cmd, e.word, e.sop, e.eop, e.is_data, e.cmd);
                    end
                end
                xfer_cyc.push_back(cyc);
            end
            occ    = occ + pend_m - c;
            pend_m = o_fifo_rd ? 1 : 0;
        end
    endtask

    task automatic tick();
        @(negedge clk);
        checkOutput();
        @(posedge clk);
        #1;
    endtask

    task automatic addVec(input logic [31:0] w, input logic s, input logic e, input logic d, input logic [7:0] c);
        vec_t v;
        v.word = w; v.sop = s; v.eop = e; v.is_data = d; v.cmd = c;
        tbl.push_back(v);
    endtask

    task automatic applyStimulus(input vec_t v, input bit expect_it);
        fifo_q.push_back(v.word);
        i_fifo_empty = 1'b0;
        if (expect_it) exp_q.push_back(v);
    endtask

    task automatic applyTable();
        for (int i = 0; i < tbl.size(); i++) applyStimulus(tbl[i], 1'b1);
        tbl.delete();
    endtask

    task automatic drain(input string name, input int budget, input bit toggle);
        int n;
        n = 0;
        while (exp_q.size() != 0 && n < budget) begin
            if (toggle) i_ready = ready_pat[n % 4];
            tick();
            n++;
        end
        i_ready = 1'b1;
        chk(name, 32'(exp_q.size()), 32'd0);
        exp_q.delete();
    endtask

    task automatic checkResetValues(input string name);
        chk({name, "_rd"},    {31'd0, o_fifo_rd}, 32'd0);
        chk({name, "_valid"}, {31'd0, o_valid},   32'd0);
        chk({name, "_sop"},   {31'd0, o_sop},     32'd0);
        chk({name, "_eop"},   {31'd0, o_eop},     32'd0);
        chk({name, "_data"},  {31'd0, o_is_data}, 32'd0);
        chk({name, "_cmd"},   {24'd0, o_cmd},     32'd0);
        chk({name, "_word"},  o_word,             32'd0);
        chk({name, "_busy"},  {31'd0, o_busy},    32'd0);
    endtask

    task automatic flushAll();
        fifo_q.delete();
        i_fifo_empty = 1'b1;
        exp_q.delete();
        tbl.delete();
    endtask

    initial begin
        vec_t v;
        bit   found;

        nRst = 1'b0;
        repeat (3) tick();
        checkResetValues("reset");
        nRst = 1'b1;
        tick();

        // Flat triangle, words present back to back
        addVec(32'h2011_2233, 1'b1, 1'b0, 1'b0, 8'h20);
        addVec(32'h0010_0010, 1'b0, 1'b0, 1'b0, 8'h20);
        addVec(32'h0020_0020, 1'b0, 1'b0, 1'b0, 8'h20);
        addVec(32'h0030_0030, 1'b0, 1'b1, 1'b0, 8'h20);
        xfer_cyc.delete();
        applyTable();
        drain("tri_drain", 40, 1'b0);
        chk("tri_xfers", 32'(xfer_cyc.size()), 32'd4);
        if (xfer_cyc.size() == 4) chk("tri_back_to_back", 32'(xfer_cyc[3] - xfer_cyc[0]), 32'd3);
        chk("idle_busy", {31'd0, o_busy}, 32'd0);

        // Textured gouraud quad
        addVec(32'h3C00_0000, 1'b1, 1'b0, 1'b0, 8'h3C);
        for (int i = 1; i <= 11; i++) addVec({16'(i), 16'(i)}, 1'b0, i == 11, 1'b0, 8'h3C);
        applyTable();
        drain("quad_drain", 80, 1'b0);

        // Polylines, misc lengths, single-word commands
        addVec(32'h48FF_FFFF, 1'b1, 1'b0, 1'b0, 8'h48);
        addVec(32'h0001_0001, 1'b0, 1'b0, 1'b0, 8'h48);
        addVec(32'h0002_0002, 1'b0, 1'b0, 1'b0, 8'h48);
        addVec(32'h0003_0003, 1'b0, 1'b0, 1'b0, 8'h48);
        addVec(32'h5555_5555, 1'b0, 1'b1, 1'b0, 8'h48);
        addVec(32'hE100_0000, 1'b1, 1'b1, 1'b0, 8'hE1);
        addVec(32'h58FF_0000, 1'b1, 1'b0, 1'b0, 8'h58);
        addVec(32'h0001_0001, 1'b0, 1'b0, 1'b0, 8'h58);
        addVec(32'h00FF_00FF, 1'b0, 1'b0, 1'b0, 8'h58);
        addVec(32'h0002_0002, 1'b0, 1'b0, 1'b0, 8'h58);
        addVec(32'h0000_FF00, 1'b0, 1'b0, 1'b0, 8'h58);
        addVec(32'h0003_0003, 1'b0, 1'b0, 1'b0, 8'h58);
        addVec(32'h5000_5000, 1'b0, 1'b1, 1'b0, 8'h58);
        addVec(32'hC000_0000, 1'b1, 1'b0, 1'b0, 8'hC0);
        addVec(32'h0000_0000, 1'b0, 1'b0, 1'b0, 8'hC0);
        addVec(32'h0001_0001, 1'b0, 1'b1, 1'b0, 8'hC0);
        addVec(32'h6800_0000, 1'b1, 1'b0, 1'b0, 8'h68);
        addVec(32'h0000_0000, 1'b0, 1'b1, 1'b0, 8'h68);
        addVec(32'h7C00_0000, 1'b1, 1'b0, 1'b0, 8'h7C);
        addVec(32'h0000_0000, 1'b0, 1'b0, 1'b0, 8'h7C);
        addVec(32'h0004_0004, 1'b0, 1'b1, 1'b0, 8'h7C);
        applyTable();
        drain("line_drain", 120, 1'b0);

        // CPU to VRAM transfers: 3x3 -> 5 data words, 3x1 -> 2 data words
        addVec(32'hA000_0000, 1'b1, 1'b0, 1'b0, 8'hA0);
        addVec(32'h0010_0010, 1'b0, 1'b0, 1'b0, 8'hA0);
        addVec(32'h0003_0003, 1'b0, 1'b0, 1'b0, 8'hA0);
        for (int i = 0; i < 5; i++) addVec(32'hD000_0000 + 32'(i), 1'b0, i == 4, 1'b1, 8'hA0);
        addVec(32'hA000_0000, 1'b1, 1'b0, 1'b0, 8'hA0);
        addVec(32'h0000_0000, 1'b0, 1'b0, 1'b0, 8'hA0);
        addVec(32'h0001_0003, 1'b0, 1'b0, 1'b0, 8'hA0);
        addVec(32'hD100_0000, 1'b0, 1'b0, 1'b1, 8'hA0);
        addVec(32'hD100_0001, 1'b0, 1'b1, 1'b1, 8'hA0);
        addVec(32'hE300_0000, 1'b1, 1'b1, 1'b0, 8'hE3);
        applyTable();
        drain("vram_drain", 80, 1'b0);

        // Twenty preloaded words with downstream ready pattern 1,0,0,1
        addVec(32'h2000_0000, 1'b1, 1'b0, 1'b0, 8'h20);
        addVec(32'h0000_0001, 1'b0, 1'b0, 1'b0, 8'h20);
        addVec(32'h0000_0002, 1'b0, 1'b0, 1'b0, 8'h20);
        addVec(32'h0000_0003, 1'b0, 1'b1, 1'b0, 8'h20);
        addVec(32'h0212_3456, 1'b1, 1'b0, 1'b0, 8'h02);
        addVec(32'h0000_0000, 1'b0, 1'b0, 1'b0, 8'h02);
        addVec(32'h0010_0010, 1'b0, 1'b1, 1'b0, 8'h02);
        addVec(32'h6000_0000, 1'b1, 1'b0, 1'b0, 8'h60);
        addVec(32'h0000_0005, 1'b0, 1'b0, 1'b0, 8'h60);
        addVec(32'h0001_0001, 1'b0, 1'b1, 1'b0, 8'h60);
        addVec(32'h6400_0000, 1'b1, 1'b0, 1'b0, 8'h64);
        addVec(32'h0000_0006, 1'b0, 1'b0, 1'b0, 8'h64);
        addVec(32'h0000_0007, 1'b0, 1'b0, 1'b0, 8'h64);
        addVec(32'h0010_0010, 1'b0, 1'b1, 1'b0, 8'h64);
        addVec(32'h8000_0000, 1'b1, 1'b0, 1'b0, 8'h80);
        addVec(32'h0000_0001, 1'b0, 1'b0, 1'b0, 8'h80);
        addVec(32'h0000_0002, 1'b0, 1'b0, 1'b0, 8'h80);
        addVec(32'h0000_0003, 1'b0, 1'b1, 1'b0, 8'h80);
        addVec(32'hE300_0000, 1'b1, 1'b1, 1'b0, 8'hE3);
        addVec(32'h0100_0000, 1'b1, 1'b1, 1'b0, 8'h01);
        applyTable();
        drain("toggle_drain", 200, 1'b1);

        // Size word 0 wraps to 1024x512: the packet must stay open well past 40 words
        addVec(32'hA000_0000, 1'b1, 1'b0, 1'b0, 8'hA0);
        addVec(32'h0000_0000, 1'b0, 1'b0, 1'b0, 8'hA0);
        addVec(32'h0000_0000, 1'b0, 1'b0, 1'b0, 8'hA0);
        for (int i = 0; i < 40; i++) addVec(32'hDA00_0000 + 32'(i), 1'b0, 1'b0, 1'b1, 8'hA0);
        applyTable();
        drain("vram0_drain", 200, 1'b0);
        chk("vram0_busy_open", {31'd0, o_busy}, 32'd1);
        nRst = 1'b0;
        #1;
        checkResetValues("reset_data");
        flushAll();
        tick();
        nRst = 1'b1;
        tick();

        // Reset while the 5th word of a 0x3C packet sits at the buffer head
        addVec(32'h3C00_0000, 1'b1, 1'b0, 1'b0, 8'h3C);
        for (int i = 1; i <= 11; i++) addVec({16'h0B00 + 16'(i), 16'(i)}, 1'b0, i == 11, 1'b0, 8'h3C);
        for (int i = 0; i < tbl.size(); i++) applyStimulus(tbl[i], i < 4);
        v = tbl[4];
        tbl.delete();
        found = 1'b0;
        for (int n = 0; n < 60 && !found; n++) begin
            tick();
            if (o_valid && o_word == v.word) found = 1'b1;
        end
        chk("rst_fifth_at_head", {31'd0, found}, 32'd1);
        chk("rst_first_four_taken", 32'(exp_q.size()), 32'd0);
        nRst = 1'b0;
        #1;
        checkResetValues("reset_mid");
        flushAll();
        tick();
        tick();
        nRst = 1'b1;
        addVec(32'hE100_0000, 1'b1, 1'b1, 1'b0, 8'hE1);
        addVec(32'h2000_0000, 1'b1, 1'b0, 1'b0, 8'h20);
        addVec(32'h0000_0001, 1'b0, 1'b0, 1'b0, 8'h20);
        addVec(32'h0000_0002, 1'b0, 1'b0, 1'b0, 8'h20);
        addVec(32'h0000_0003, 1'b0, 1'b1, 1'b0, 8'h20);
        applyTable();
        drain("post_reset_drain", 40, 1'b0);
        chk("final_idle_busy", {31'd0, o_busy}, 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
